idct_col_sched: RTL and testbench

//  Scheduler/controller for the column IDCT datapath (idct_col). Gathers one column of

---
 rtl/idct_pkg.sv | 28 ++
 rtl/idct_sync_fifo.sv | 59 +++++
 rtl/idct_col_sched.sv | 171 +++++++++++++++++
 tb/tb_idct_col_sched.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared definitions for the column IDCT scheduler: size encodings, default widths,
// datapath latency and controller state encoding.
package idct_pkg;

  localparam int WIDTH_X = 16;
  localparam int LAT_COL = 12;
  localparam int MAX_N   = 8;

  localparam logic [1:0] SZ4 = 2'b01;
  localparam logic [1:0] SZ8 = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_COLLECT
  } col_state_e;

  function automatic logic size_legal(input logic [1:0] sz);
    return (sz == SZ4) || (sz == SZ8);
  endfunction

  function automatic logic [3:0] col_len(input logic [1:0] sz);
    return (sz == SZ8) ? 4'd8 : 4'd4;
  endfunction

endpackage

// File: rtl/idct_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible while non-empty.
// A push into a full FIFO is dropped and flagged unless a pop frees a slot that cycle.
module idct_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o    = (count_q == '0);
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign pop_ok     = pop_i & ~empty_o;
  assign push_ok    = push_i & (~full | pop_ok);
  assign overflow_o = push_i & ~push_ok;
  assign rdata_o    = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity, and a
  // reset-free array maps onto plain memory cells.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/idct_col_sched.sv
// Column IDCT scheduler: gathers a column, streams it gap-free into the fixed-latency
// datapath, and captures the serial results into an output FIFO.
module idct_col_sched #(
  parameter int WIDTH_X    = idct_pkg::WIDTH_X,
  parameter int LAT        = idct_pkg::LAT_COL,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         cfg_idct4,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_X-1:0] in_data,
  input  logic               in_last,
  output logic               dp_start,
  output logic [1:0]         dp_idct4,
  output logic [WIDTH_X-1:0] dp_x,
  input  logic [WIDTH_X-1:0] dp_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_X-1:0] out_data,
  output logic               out_last,
  output logic               err,
  output logic               busy
);

  import idct_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = $clog2(LAT + 1);
  // A new column is admitted only when a worst-case column fits in the FIFO.
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH - MAX_N);

  col_state_e         state_q;
  logic [1:0]         size_q;
  logic [3:0]         cnt_q;
  logic [LW-1:0]      lat_q;
  logic [WIDTH_X-1:0] stage_q [MAX_N];
  logic               in_ready_q;
  logic               dp_start_q;
  logic [1:0]         dp_idct4_q;
  logic [WIDTH_X-1:0] dp_x_q;
  logic               err_q;

  logic [3:0]         n_cur;
  logic [LW-1:0]      wait_last;
  logic               beat;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_overflow;
  logic [CW-1:0]      fifo_count;
  logic [WIDTH_X:0]   fifo_rdata;
  logic               credit_ok;

  assign n_cur     = col_len(size_q);
  assign wait_last = LW'(LAT - 1 - int'(n_cur));
  assign beat      = in_valid & in_ready_q;
  assign credit_ok = (fifo_count <= CREDIT_MAX);
  assign fifo_push = (state_q == ST_COLLECT);
  assign fifo_pop  = out_valid & out_ready;

  idct_sync_fifo #(
    .WIDTH (WIDTH_X + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .wdata_i    ({cnt_q == (n_cur - 4'd1), dp_y}),
    .pop_i      (fifo_pop),
    .rdata_o    (fifo_rdata),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .overflow_o (fifo_overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      size_q     <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      in_ready_q <= 1'b0;
      dp_start_q <= 1'b0;
      dp_idct4_q <= '0;
      dp_x_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (fifo_overflow) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!size_legal(cfg_idct4)) begin
            err_q <= 1'b1;
          end else if (credit_ok) begin
            size_q     <= cfg_idct4;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            if (cnt_q == n_cur - 4'd1) begin
              in_ready_q <= 1'b0;
              if (in_last) begin
                // First coefficient goes out on the same edge that closes the load.
                dp_start_q <= 1'b1;
                dp_x_q     <= stage_q[0];
                dp_idct4_q <= size_q;
                cnt_q      <= 4'd1;
                state_q    <= ST_ISSUE;
              end else begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
              end
            end else if (in_last) begin
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        ST_ISSUE: begin
          if (cnt_q == n_cur) begin
            dp_start_q <= 1'b0;
            lat_q      <= '0;
            state_q    <= ST_WAIT;
          end else begin
            dp_x_q <= stage_q[cnt_q[2:0]];
            cnt_q  <= cnt_q + 4'd1;
          end
        end
        ST_WAIT: begin
          if (lat_q == wait_last) begin
            cnt_q   <= '0;
            state_q <= ST_COLLECT;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        ST_COLLECT: begin
          if (cnt_q == n_cur - 4'd1) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == ST_LOAD) && beat) stage_q[cnt_q[2:0]] <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign dp_start  = dp_start_q;
  assign dp_idct4  = dp_idct4_q;
  assign dp_x      = dp_x_q;
  assign err       = err_q;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_rdata[WIDTH_X-1:0];
  assign out_last  = ~fifo_empty & fifo_rdata[WIDTH_X];
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_idct_col_sched.sv
// Bench for idct_col_sched: a delay-line datapath model, issue/pop monitors and a
// queue-based expectation of coefficients and results per column.
module tb_idct_col_sched;
  import idct_pkg::*;

  localparam int W = 16;
  localparam int L = 12;
  localparam int D = 16;

  logic         clk;
  logic         rst_n;
  logic [1:0]   cfg_idct4;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         dp_start;
  logic [1:0]   dp_idct4;
  logic [W-1:0] dp_x;
  logic [W-1:0] dp_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         err;
  logic         busy;

  idct_col_sched #(.WIDTH_X(W), .LAT(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_idct4(cfg_idct4),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dp_start(dp_start), .dp_idct4(dp_idct4), .dp_x(dp_x), .dp_y(dp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err), .busy(busy)
  );

  typedef struct { logic [W-1:0] x; logic [1:0] sz; int c; } issue_t;
  typedef struct { logic [W-1:0] d; logic l; } res_t;

  issue_t       issue_q [$];
  res_t         pop_q   [$];
  res_t         exp_q   [$];
  logic [W-1:0] exp_x_q [$];
  logic [W-1:0] hist_x  [64];
  logic         hist_s  [64];
  logic [W-1:0] col_x   [8];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_ready = 0;

  string rst_names [8] = '{"in_ready", "dp_start", "dp_idct4", "dp_x",
                           "out_valid", "out_last", "err", "busy"};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: any fixed invertible mapping, delivered exactly L cycles after the strobe.
  function automatic logic [W-1:0] dp_model(input logic [W-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'hA5A5;
  endfunction

  // Negedge monitor: cyc identifies the current cycle; at posedge+1 cyc equals the cycle just begun.
  always @(negedge clk) begin
    hist_s[cyc % 64] = dp_start;
    hist_x[cyc % 64] = dp_x;
    if (dp_start) issue_q.push_back('{dp_x, dp_idct4, cyc});
    if (out_valid && out_ready) pop_q.push_back('{out_data, out_last});
    if (cyc >= L && hist_s[(cyc - L) % 64]) dp_y = dp_model(hist_x[(cyc - L) % 64]);
    else                                    dp_y = 16'hBAD0 ^ 16'(cyc);
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic snap_outputs(output logic [W-1:0] v [8]);
    v[0] = W'(in_ready);  v[1] = W'(dp_start); v[2] = W'(dp_idct4); v[3] = dp_x;
    v[4] = W'(out_valid); v[5] = W'(out_last); v[6] = W'(err);      v[7] = W'(busy);
  endtask

  task automatic do_reset(input logic [1:0] sz);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    cfg_idct4 = sz; rand_ready = 0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue_q.delete(); pop_q.delete(); exp_q.delete(); exp_x_q.delete();
  endtask

  task automatic random_column(input int n);
    for (int i = 0; i < 8; i++) col_x[i] = (i < n) ? 16'($urandom) : '0;
  endtask

  task automatic expect_column(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{dp_model(col_x[i]), (i == n - 1)});
      exp_x_q.push_back(col_x[i]);
    end
  endtask

  task automatic send_column(input int nb, input int last_at, input bit gaps, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < nb; i++) begin
      int t;
      if (gaps) repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = col_x[i]; in_last = (i == last_at);
      t = 0;
      while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
      if (!in_ready) begin
        ok = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_pops(input int n, output bit ok);
    int t = 0;
    while (pop_q.size() < n && t < 3000) begin @(posedge clk); #1; t++; end
    ok = (pop_q.size() >= n);
  endtask

  task automatic wait_issues(input int n, output bit ok);
    int t = 0;
    while (issue_q.size() < n && t < 3000) begin @(posedge clk); #1; t++; end
    ok = (issue_q.size() >= n);
  endtask

  task automatic test_reset;
    logic [W-1:0] v [8];
    do_reset(SZ8);
    snap_outputs(v);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (v[i] !== '0) begin
        failures++;
        $display("FAIL reset_%s got=%h want=0", rst_names[i], v[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b want=1", in_ready); end
    for (int k = 0; k < 2; k++) begin
      rst_n = 1'b0; cfg_idct4 = (k == 0) ? 2'b00 : 2'b11;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL illegal_cfg_%b got err=%b in_ready=%b want err=1 in_ready=0", cfg_idct4, err, in_ready);
      end
    end
  endtask

  task automatic test_col8;
    bit ok;
    do_reset(SZ8);
    col_x = '{16'd64, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    expect_column(8);
    send_column(8, 7, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL col8_send got=timeout want=accepted"); end
    random_column(8);
    expect_column(8);
    send_column(8, 7, 1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL col8_send2 got=timeout want=accepted"); end
    wait_issues(16, ok);
    wait_pops(16, ok);
    checks++;
    if (!ok || issue_q.size() != 16) begin
      failures++;
      $display("FAIL col8_counts got issues=%0d pops=%0d want 16/16", issue_q.size(), pop_q.size());
    end
    for (int i = 0; i < 16 && i < issue_q.size(); i++) begin
      int base;
      base = issue_q[(i / 8) * 8].c;
      checks++;
      if (issue_q[i].x !== exp_x_q[i] || issue_q[i].sz !== SZ8 || issue_q[i].c != base + i % 8) begin
        failures++;
        $display("FAIL col8_issue[%0d] got x=%h sz=%b cyc=%0d want x=%h sz=%b cyc=%0d",
                 i, issue_q[i].x, issue_q[i].sz, issue_q[i].c, exp_x_q[i], SZ8, base + i % 8);
      end
    end
    for (int i = 0; i < 16 && i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i].d !== exp_q[i].d || pop_q[i].l !== exp_q[i].l) begin
        failures++;
        $display("FAIL col8_result[%0d] got=%h/%b want=%h/%b", i, pop_q[i].d, pop_q[i].l, exp_q[i].d, exp_q[i].l);
      end
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL col8_err got=%b want=0", err); end
  endtask

  task automatic test_col4_gaps;
    bit ok;
    do_reset(SZ4);
    col_x = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
    expect_column(4);
    send_column(4, 3, 1, ok);
    for (int k = 0; k < 2; k++) begin
      random_column(4);
      expect_column(4);
      send_column(4, 3, 1, ok);
    end
    wait_issues(12, ok);
    wait_pops(12, ok);
    checks++;
    if (!ok || issue_q.size() != 12) begin
      failures++;
      $display("FAIL col4_counts got issues=%0d pops=%0d want 12/12", issue_q.size(), pop_q.size());
    end
    for (int i = 0; i < 12 && i < issue_q.size(); i++) begin
      int base;
      base = issue_q[(i / 4) * 4].c;
      checks++;
      if (issue_q[i].x !== exp_x_q[i] || issue_q[i].sz !== SZ4 || issue_q[i].c != base + i % 4) begin
        failures++;
        $display("FAIL col4_issue[%0d] got x=%h sz=%b cyc=%0d want x=%h sz=%b cyc=%0d",
                 i, issue_q[i].x, issue_q[i].sz, issue_q[i].c, exp_x_q[i], SZ4, base + i % 4);
      end
    end
    for (int i = 0; i < 12 && i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i].d !== exp_q[i].d || pop_q[i].l !== exp_q[i].l) begin
        failures++;
        $display("FAIL col4_result[%0d] got=%h/%b want=%h/%b", i, pop_q[i].d, pop_q[i].l, exp_q[i].d, exp_q[i].l);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int hi = 0;
    do_reset(SZ8);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      random_column(8);
      expect_column(8);
      send_column(8, 7, 0, ok);
    end
    repeat (30) @(posedge clk);
    repeat (20) begin @(posedge clk); #1; if (in_ready) hi++; end
    checks++;
    if (hi != 0 || out_valid !== 1'b1 || pop_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_blocked got ready_cycles=%0d out_valid=%b pops=%0d want 0/1/0", hi, out_valid, pop_q.size());
    end
    rand_ready = 1;
    random_column(8);
    expect_column(8);
    send_column(8, 7, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_send3 got=timeout want=accepted"); end
    wait_pops(24, ok);
    rand_ready = 0;
    out_ready = 1'b1;
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_pop_count got=%0d want=24", pop_q.size()); end
    for (int i = 0; i < 24 && i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i].d !== exp_q[i].d || pop_q[i].l !== exp_q[i].l) begin
        failures++;
        $display("FAIL b2b_result[%0d] got=%h/%b want=%h/%b", i, pop_q[i].d, pop_q[i].l, exp_q[i].d, exp_q[i].l);
      end
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b want=0", err); end
  endtask

  task automatic test_fifo_simul;
    bit ok;
    int target;
    int t = 0;
    do_reset(SZ8);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      random_column(8);
      expect_column(8);
      send_column(8, 7, 0, ok);
    end
    wait_issues(16, ok);
    // Eighth push of the second column lands on an occupancy of 15.
    target = issue_q[8].c + L + 7;
    while (cyc < target && t < 200) begin @(posedge clk); #1; t++; end
    checks++;
    if (cyc != target) begin failures++; $display("FAIL simul_align got cyc=%0d want=%0d", cyc, target); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (pop_q.size() != 1 || err !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL simul_hold got pops=%0d err=%b out_valid=%b want 1/0/1", pop_q.size(), err, out_valid);
    end
    out_ready = 1'b1;
    wait_pops(16, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pop_q.size() != 16 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_count got pops=%0d out_valid=%b want 16/0", pop_q.size(), out_valid);
    end
    for (int i = 0; i < 16 && i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i].d !== exp_q[i].d || pop_q[i].l !== exp_q[i].l) begin
        failures++;
        $display("FAIL simul_result[%0d] got=%h/%b want=%h/%b", i, pop_q[i].d, pop_q[i].l, exp_q[i].d, exp_q[i].l);
      end
    end
  endtask

  task automatic test_framing;
    bit ok;
    do_reset(SZ8);
    random_column(8);
    send_column(3, 2, 0, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || issue_q.size() != 0) begin
      failures++;
      $display("FAIL frame_early got err=%b issues=%0d want 1/0", err, issue_q.size());
    end
    random_column(8);
    send_column(8, -1, 0, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (!ok || issue_q.size() != 0) begin
      failures++;
      $display("FAIL frame_nolast got accepted=%b issues=%0d want 1/0", ok, issue_q.size());
    end
    random_column(8);
    expect_column(8);
    send_column(8, 7, 0, ok);
    wait_pops(8, ok);
    checks++;
    if (!ok || issue_q.size() != 8 || err !== 1'b1) begin
      failures++;
      $display("FAIL frame_recover got pops=%0d issues=%0d err=%b want 8/8/1", pop_q.size(), issue_q.size(), err);
    end
    for (int i = 0; i < 8 && i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i].d !== exp_q[i].d || pop_q[i].l !== exp_q[i].l) begin
        failures++;
        $display("FAIL frame_result[%0d] got=%h/%b want=%h/%b", i, pop_q[i].d, pop_q[i].l, exp_q[i].d, exp_q[i].l);
      end
    end
  endtask

  task automatic test_reset_in_issue;
    bit ok;
    logic [W-1:0] v [8];
    do_reset(SZ8);
    random_column(8);
    send_column(8, 7, 0, ok);
    checks++;
    if (dp_start !== 1'b1) begin failures++; $display("FAIL rst_issue_pre got dp_start=%b want=1", dp_start); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    snap_outputs(v);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (v[i] !== '0) begin
        failures++;
        $display("FAIL rst_issue_%s got=%h want=0", rst_names[i], v[i]);
      end
    end
    pop_q.delete();
    repeat (L + 20) @(posedge clk);
    #1;
    checks++;
    if (pop_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_issue_flush got pops=%0d out_valid=%b want 0/0", pop_q.size(), out_valid);
    end
  endtask

  initial begin
    dp_y = '0;
    test_reset;
    test_col8;
    test_col4_gaps;
    test_back_to_back;
    test_fifo_simul;
    test_framing;
    test_reset_in_issue;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
